dht11_frame_parser: RTL and testbench

- Receive-side parser for the DHT11 single-wire temperature/humidity sensor.
- Times the sensor's response pulse and 40 data-bit pulses on the sampled line `inp`.
- Decodes each bit by high-pulse width, MSB first, and presents the completed 40-bit frame on `out`.
- Sits behind the bus driver that issues the 18 ms host start pulse; `en_set` arms it once the host releases the line.

---
 rtl/dht11_pkg.sv | 30 +++
 rtl/dht11_sync_edge.sv | 39 +++
 rtl/dht11_frame_parser.sv | 106 ++++++++++
 tb/tb_dht11_frame_parser.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dht11_pkg
// Brief    : Shared state encoding, frame width and checksum helper for the
//            DHT11 frame parser.
// Revision : 1.0 - initial release
// ============================================================================
package dht11_pkg;

  localparam int FRAME_BITS = 40;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RESP = 3'd1,
    RESP_LOW  = 3'd2,
    RESP_HIGH = 3'd3,
    BIT_LOW   = 3'd4,
    BIT_HIGH  = 3'd5,
    DONE      = 3'd6
  } state_t;

  // Low byte must equal the 8-bit wrapped sum of the four data bytes.
  function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return (sum == frame[7:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : dht11_sync_edge
// Brief    : Two-flop synchronizer for the DHT11 data line with single-cycle
//            rise/fall pulses derived from the synchronized level.
// Revision : 1.0 - initial release
// ============================================================================
module dht11_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops reset to the idle-high line level so leaving reset makes no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/dht11_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : dht11_frame_parser
// Brief    : Times the DHT11 response and 40 data-bit pulses, decodes bits by
//            high-pulse width (MSB first) and publishes completed frames.
//            Optional checksum gating via macro DHT11_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dht11_frame_parser
  import dht11_pkg::*;
#(
  parameter int CLKS_PER_US   = 100,
  parameter int ONE_THRESH_US = 45,
  parameter int TIMEOUT_US    = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_set,
  input  logic                  inp,
  output logic [FRAME_BITS-1:0] out
);

  localparam logic [15:0] c_ONE_CLKS     = 16'(ONE_THRESH_US * CLKS_PER_US);
  localparam logic [15:0] c_TIMEOUT_CLKS = 16'(TIMEOUT_US * CLKS_PER_US);
  localparam logic [5:0]  c_LAST_BIT     = 6'(FRAME_BITS - 1);

  state_t                r_state;
  state_t                w_next;
  logic [FRAME_BITS-1:0] r_shift;
  logic [5:0]            r_bit_cnt;
  logic [15:0]           r_cnt;
  logic                  w_level;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_timeout;
  logic                  w_shift_en;
  logic                  w_frame_ok;

  dht11_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_d     (inp),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_timeout = (r_cnt >= c_TIMEOUT_CLKS);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (en_set) w_next = WAIT_RESP;
      WAIT_RESP: if (w_fall) w_next = RESP_LOW;
      RESP_LOW:  if (w_timeout) w_next = WAIT_RESP;
                 else if (w_rise) w_next = RESP_HIGH;
      RESP_HIGH: if (w_timeout) w_next = WAIT_RESP;
                 else if (w_fall) w_next = BIT_LOW;
      BIT_LOW:   if (w_timeout) w_next = WAIT_RESP;
                 else if (w_rise) w_next = BIT_HIGH;
      BIT_HIGH:  if (w_timeout) w_next = WAIT_RESP;
                 else if (w_fall) w_next = (r_bit_cnt == c_LAST_BIT) ? DONE : BIT_LOW;
      DONE:      w_next = WAIT_RESP;
      default:   w_next = IDLE;
    endcase
    // Disable overrides everything, including a frame completing this cycle.
    if (!en_set) w_next = IDLE;
  end

  assign w_shift_en = (r_state == BIT_HIGH) && ((w_next == BIT_LOW) || (w_next == DONE));

`ifdef DHT11_CHECKSUM_EN
  assign w_frame_ok = checksum_ok(r_shift);
`else
  assign w_frame_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      out       <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;

      if (w_shift_en) begin
        r_shift   <= {r_shift[FRAME_BITS-2:0], (r_cnt >= c_ONE_CLKS)};
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end else if ((w_next == WAIT_RESP) || (w_next == IDLE)) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end

      if ((r_state == DONE) && (w_next == WAIT_RESP) && w_frame_ok) out <= r_shift;
    end
  end

  logic w_unused;
  assign w_unused = w_level;

endmodule
`default_nettype wire

// File: tb/tb_dht11_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht11_frame_parser
// Brief    : Scoreboard bench for dht11_frame_parser, run at 1 clk per us.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dht11_frame_parser;
  import dht11_pkg::*;

  localparam int US = 1;
`ifdef DHT11_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef struct {
    logic [39:0] data;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_set;
  logic        inp;
  logic [39:0] out;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_fall_cyc = 0;
  bit          mon_en = 1'b0;
  logic [39:0] prev_out;
  logic [39:0] last_good;

  dht11_frame_parser #(
    .CLKS_PER_US   (US),
    .ONE_THRESH_US (45),
    .TIMEOUT_US    (200)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en_set (en_set),
    .inp    (inp),
    .out    (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && (out !== prev_out)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out: got %h, expected unchanged %h", out, prev_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out !== e.data) begin
          errors++;
          $display("FAIL frame_value: got %h, expected %h", out, e.data);
        end
        if (e.lat) begin
          checks++;
          if (cyc - last_fall_cyc > 4) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected <= 4", cyc - last_fall_cyc);
          end
        end
      end
      prev_out = out;
    end
  end

  task automatic level(input logic v, input int us);
    if (inp && !v) last_fall_cyc = cyc;
    inp = v;
    repeat (us * US) @(posedge clk);
    #1;
  endtask

  function automatic bit tb_sum_ok(input logic [39:0] f);
    int s;
    s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    return s == int'(f[7:0]);
  endfunction

  // Full frames (nbits == 40) end with the final falling edge and a low tail.
  task automatic send_frame(input logic [39:0] f, input int nbits,
                            input int hi0, input int hi1, input bit expect_load);
    if (expect_load && (!CK_EN || tb_sum_ok(f))) begin
      q.push_back('{data: f, lat: 1'b1});
      last_good = f;
    end
    level(1'b1, 45);
    level(1'b0, 80);
    level(1'b1, 80);
    for (int i = 0; i < nbits; i++) begin
      level(1'b0, 54);
      level(1'b1, f[39-i] ? hi1 : hi0);
    end
    if (nbits == 40) level(1'b0, 60);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending frames, expected 0", name, q.size());
    end
  endtask

  task automatic check_out(input string name, input logic [39:0] exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, out, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en_set = 1'b0; inp = 1'b0; last_good = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_out("reset_out", 40'h0);
    prev_out = out;
    mon_en = 1'b1;

    level(1'b0, 18000);
    en_set = 1'b1;
    send_frame(40'h005A00328C, 40, 24, 70, 1'b1);
    drain("nominal_drain");
    level(1'b0, 300);
    check_out("hold_low_stable", 40'h005A00328C);

    send_frame(40'hA55A0FF0FE, 40, 44, 46, 1'b1);
    drain("threshold_drain");

    send_frame(40'h005A00328C, 20, 24, 70, 1'b0);
    level(1'b0, 54);
    en_set = 1'b0;
    level(1'b1, 50);
    check_out("disable_keeps", 40'hA55A0FF0FE);
    en_set = 1'b1;
    level(1'b1, 10);
    send_frame(40'h005A00328C, 40, 24, 70, 1'b1);
    drain("rearm_drain");

    send_frame(40'h010203040A, 12, 24, 70, 1'b0);
    level(1'b1, 300);
    check_out("timeout_keeps", 40'h005A00328C);
    send_frame(40'h010203040A, 40, 24, 70, 1'b1);
    drain("after_timeout_drain");

    send_frame(40'h005A00328D, 40, 24, 70, 1'b1);
    drain("checksum_drain");
    level(1'b0, 100);
    check_out("checksum_result", last_good);

    send_frame(40'hA55A0FF0FE, 10, 24, 70, 1'b0);
    q.push_back('{data: 40'h0, lat: 1'b0});
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", dut.r_state, IDLE);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drain("reset_drain");
    level(1'b1, 20);
    send_frame(40'h010203040A, 40, 24, 70, 1'b1);
    drain("post_reset_drain");
    level(1'b0, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
